// File: rtl/control_rtc_secuencia_pkg.sv
// Shared types and constants for the RTC read-sweep / keyboard-write sequencer.
package control_rtc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        RD_LATCH,
        WR_REQ,
        WR_WAIT
    } st_e;

    // RTC register map: time, date, timer (three digits pairs each)
    localparam logic [3:0] ADDR_HO     = 4'd0;
    localparam logic [3:0] ADDR_MI     = 4'd1;
    localparam logic [3:0] ADDR_SE     = 4'd2;
    localparam logic [3:0] ADDR_DI     = 4'd3;
    localparam logic [3:0] ADDR_ME     = 4'd4;
    localparam logic [3:0] ADDR_AN     = 4'd5;
    localparam logic [3:0] ADDR_HO_TI  = 4'd6;
    localparam logic [3:0] ADDR_MI_TI  = 4'd7;
    localparam logic [3:0] ADDR_SEG_TI = 4'd8;

    localparam logic [7:0] SC_FECHA = 8'h7d;
    localparam logic [7:0] SC_HORA  = 8'h6c;
    localparam logic [7:0] SC_TIMER = 8'h75;

    localparam logic [7:0] TIMEOUT_MAX = 8'd255;

endpackage

// File: rtl/control_rtc_secuencia_if.sv
// Handshake bundle between the sequencer, keyboard/refresh sources and RTC bus driver.
interface control_rtc_secuencia_if;
    logic       tick_refresh;
    logic       wr_req;
    logic [7:0] estado;
    logic       bus_done;
    logic       bus_req;
    logic       bus_rw;
    logic [3:0] direccion;
    logic       en_out;
    logic       escribiendo;
    logic       busy;
    logic       err;

    modport slave (
        input  tick_refresh, wr_req, estado, bus_done,
        output bus_req, bus_rw, direccion, en_out, escribiendo, busy, err
    );

    modport master (
        output tick_refresh, wr_req, estado, bus_done,
        input  bus_req, bus_rw, direccion, en_out, escribiendo, busy, err
    );
endinterface

// File: rtl/control_rtc_secuencia_timeout.sv
// 8-bit bus-wait counter; tc_o flags the last allowed wait cycle.
module contador_timeout
    import control_rtc_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = 8'd0;
        else if (en_i) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= 8'd0;
        else         cnt_q <= cnt_d;
    end

    // Fires on the 255th consecutive enabled cycle
    assign tc_o = en_i && (cnt_q == TIMEOUT_MAX - 8'd1);

endmodule

// File: rtl/control_rtc_secuencia.sv
// RTC access sequencer: refresh sweeps reads, keyboard commits 3-register write groups.
// Build option: CONTROL_RTC_TIMER_EN adds the timer registers (6..8) and scan code 8'h75.
module control_rtc_secuencia
    import control_rtc_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    control_rtc_secuencia_if.slave   io
);
`ifdef CONTROL_RTC_TIMER_EN
    localparam logic [3:0] LAST_RD = ADDR_SEG_TI;
`else
    localparam logic [3:0] LAST_RD = ADDR_AN;
`endif

    st_e        state_q, state_d;
    logic [3:0] addr_q, addr_d;
    logic [3:0] rd_addr_q, rd_addr_d;
    logic [3:0] grp_q, grp_d;
    logic [1:0] wr_cnt_q, wr_cnt_d;
    logic       sweep_q, sweep_d;
    logic       wr_pend_q, wr_pend_d;
    logic       err_q, err_d;
    logic       in_wait, tc;

    assign in_wait = (state_q == RD_WAIT) || (state_q == WR_WAIT);

    contador_timeout u_tmo (
        .clk_i  (clk),
        .rst_ni (reset),
        .clr_i  (!in_wait),
        .en_i   (in_wait),
        .tc_o   (tc)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rd_addr_d = rd_addr_q;
        grp_d     = grp_q;
        wr_cnt_d  = wr_cnt_q;
        sweep_d   = sweep_q;
        wr_pend_d = wr_pend_q;
        err_d     = 1'b0;

        if (io.tick_refresh) sweep_d = 1'b1;

        // wr_pend stays set for the whole group, so it also blocks edits mid-write
        if (io.wr_req && !wr_pend_q) begin
            case (io.estado)
                SC_HORA:  begin wr_pend_d = 1'b1; grp_d = ADDR_HO;    end
                SC_FECHA: begin wr_pend_d = 1'b1; grp_d = ADDR_DI;    end
`ifdef CONTROL_RTC_TIMER_EN
                SC_TIMER: begin wr_pend_d = 1'b1; grp_d = ADDR_HO_TI; end
`endif
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (wr_pend_q) begin
                    state_d  = WR_REQ;
                    addr_d   = grp_q;
                    wr_cnt_d = 2'd0;
                end else if (sweep_q) begin
                    state_d = RD_REQ;
                    addr_d  = rd_addr_q;
                end
            end
            RD_REQ: state_d = RD_WAIT;
            RD_WAIT: begin
                if (io.bus_done) begin
                    state_d = RD_LATCH;
                end else if (tc) begin
                    state_d   = IDLE;
                    err_d     = 1'b1;
                    sweep_d   = 1'b0;
                    rd_addr_d = ADDR_HO;
                end
            end
            RD_LATCH: begin
                if (addr_q == LAST_RD) begin
                    state_d   = IDLE;
                    sweep_d   = 1'b0;
                    rd_addr_d = ADDR_HO;
                end else begin
                    addr_d    = addr_q + 4'd1;
                    rd_addr_d = addr_q + 4'd1;
                    // Yield to a pending write; IDLE resumes from rd_addr afterwards
                    state_d   = wr_pend_q ? IDLE : RD_REQ;
                end
            end
            WR_REQ: state_d = WR_WAIT;
            WR_WAIT: begin
                if (io.bus_done) begin
                    if (wr_cnt_q == 2'd2) begin
                        state_d   = IDLE;
                        wr_pend_d = 1'b0;
                    end else begin
                        state_d  = WR_REQ;
                        addr_d   = addr_q + 4'd1;
                        wr_cnt_d = wr_cnt_q + 2'd1;
                    end
                end else if (tc) begin
                    state_d   = IDLE;
                    err_d     = 1'b1;
                    wr_pend_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= 4'h0;
            rd_addr_q <= 4'h0;
            grp_q     <= 4'h0;
            wr_cnt_q  <= 2'd0;
            sweep_q   <= 1'b0;
            wr_pend_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rd_addr_q <= rd_addr_d;
            grp_q     <= grp_d;
            wr_cnt_q  <= wr_cnt_d;
            sweep_q   <= sweep_d;
            wr_pend_q <= wr_pend_d;
            err_q     <= err_d;
        end
    end

    assign io.bus_req     = (state_q == RD_REQ) || (state_q == RD_WAIT) ||
                            (state_q == WR_REQ) || (state_q == WR_WAIT);
    assign io.bus_rw      = (state_q == WR_REQ) || (state_q == WR_WAIT);
    assign io.escribiendo = io.bus_rw;
    assign io.direccion   = addr_q;
    assign io.en_out      = (state_q == RD_LATCH);
    assign io.busy        = (state_q != IDLE);
    assign io.err         = err_q;

endmodule

// File: tb/tb_control_rtc_secuencia.sv
// Directed self-checking bench for control_rtc_secuencia (honours CONTROL_RTC_TIMER_EN).
module tb_control_rtc_secuencia;
`ifdef CONTROL_RTC_TIMER_EN
    localparam logic [3:0] LAST = 4'd8;
`else
    localparam logic [3:0] LAST = 4'd5;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    control_rtc_secuencia_if bus_if ();

    control_rtc_secuencia dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus_if)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic serve_read(input logic [3:0] a, input int lat);
        int n = 0;
        while (!bus_if.bus_req && n < 30) begin cyc(); n++; end
        total++;
        if (bus_if.bus_req !== 1'b1 || bus_if.bus_rw !== 1'b0 || bus_if.direccion !== a) begin
            bad++;
            $display("FAIL rd_req a=%0d: req=%b rw=%b dir=%0d want req=1 rw=0 dir=%0d",
                     a, bus_if.bus_req, bus_if.bus_rw, bus_if.direccion, a);
        end
        repeat (lat + 1) cyc();
        bus_if.bus_done = 1'b1;
        cyc();
        bus_if.bus_done = 1'b0;
        total++;
        if (bus_if.en_out !== 1'b1 || bus_if.bus_req !== 1'b0 || bus_if.direccion !== a) begin
            bad++;
            $display("FAIL rd_latch a=%0d: en=%b req=%b dir=%0d want en=1 req=0 dir=%0d",
                     a, bus_if.en_out, bus_if.bus_req, bus_if.direccion, a);
        end
        cyc();
        total++;
        if (bus_if.en_out !== 1'b0) begin
            bad++;
            $display("FAIL en_once a=%0d: en=%b want 0", a, bus_if.en_out);
        end
    endtask

    task automatic serve_write(input logic [3:0] a);
        int n = 0;
        while (!bus_if.bus_req && n < 30) begin cyc(); n++; end
        total++;
        if (bus_if.bus_req !== 1'b1 || bus_if.bus_rw !== 1'b1 ||
            bus_if.escribiendo !== 1'b1 || bus_if.direccion !== a) begin
            bad++;
            $display("FAIL wr_req a=%0d: req=%b rw=%b esc=%b dir=%0d want 1 1 1 %0d", a,
                     bus_if.bus_req, bus_if.bus_rw, bus_if.escribiendo, bus_if.direccion, a);
        end
        cyc();
        total++;
        if (bus_if.escribiendo !== 1'b1 || bus_if.bus_req !== 1'b1) begin
            bad++;
            $display("FAIL wr_wait a=%0d: esc=%b req=%b want 1 1", a,
                     bus_if.escribiendo, bus_if.bus_req);
        end
        bus_if.bus_done = 1'b1;
        cyc();
        bus_if.bus_done = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({bus_if.bus_req, bus_if.bus_rw, bus_if.en_out, bus_if.escribiendo,
             bus_if.busy, bus_if.err, bus_if.direccion} !== 10'b0) begin
            bad++;
            $display("FAIL reset_outs: req=%b rw=%b en=%b esc=%b busy=%b err=%b dir=%0d want all 0",
                     bus_if.bus_req, bus_if.bus_rw, bus_if.en_out, bus_if.escribiendo,
                     bus_if.busy, bus_if.err, bus_if.direccion);
        end
    endtask

    task automatic test_sweep();
        bus_if.tick_refresh = 1'b1;
        cyc();
        bus_if.tick_refresh = 1'b0;
        total++;
        if (bus_if.bus_req !== 1'b0) begin
            bad++; $display("FAIL lat_plus1: req=%b want 0", bus_if.bus_req);
        end
        cyc();
        total++;
        if (bus_if.bus_req !== 1'b1) begin
            bad++; $display("FAIL lat_plus2: req=%b want 1", bus_if.bus_req);
        end
        for (int i = 0; i <= int'(LAST); i++) serve_read(4'(i), i % 3);
        total++;
        if (bus_if.busy !== 1'b0) begin
            bad++; $display("FAIL sweep_end_busy: busy=%b want 0", bus_if.busy);
        end
    endtask

    task automatic test_write_fecha();
        int extra = 0;
        bus_if.wr_req = 1'b1; bus_if.estado = 8'h7d;
        cyc();
        bus_if.wr_req = 1'b0;
        serve_write(4'd3);
        // an edit committed mid-group must be dropped
        bus_if.wr_req = 1'b1; bus_if.estado = 8'h6c;
        serve_write(4'd4);
        bus_if.wr_req = 1'b0;
        serve_write(4'd5);
        total++;
        if (bus_if.escribiendo !== 1'b0 || bus_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL wr_end: esc=%b busy=%b want 0 0", bus_if.escribiendo, bus_if.busy);
        end
        repeat (10) begin cyc(); if (bus_if.bus_req) extra++; end
        total++;
        if (extra !== 0) begin
            bad++; $display("FAIL wr_midgroup_ignored: req cycles=%0d want 0", extra);
        end
    endtask

    task automatic test_interleave();
        bus_if.tick_refresh = 1'b1;
        cyc();
        bus_if.tick_refresh = 1'b0;
        serve_read(4'd0, 0);
        serve_read(4'd1, 0);
        total++;
        if (bus_if.bus_req !== 1'b1 || bus_if.direccion !== 4'd2) begin
            bad++;
            $display("FAIL il_rd2: req=%b dir=%0d want 1 2", bus_if.bus_req, bus_if.direccion);
        end
        bus_if.wr_req = 1'b1; bus_if.estado = 8'h6c;
        cyc();
        bus_if.wr_req = 1'b0;
        bus_if.bus_done = 1'b1;
        cyc();
        bus_if.bus_done = 1'b0;
        total++;
        if (bus_if.en_out !== 1'b1 || bus_if.direccion !== 4'd2) begin
            bad++;
            $display("FAIL il_latch2: en=%b dir=%0d want 1 2", bus_if.en_out, bus_if.direccion);
        end
        cyc();
        total++;
        if (bus_if.busy !== 1'b0) begin
            bad++; $display("FAIL il_yield: busy=%b want 0", bus_if.busy);
        end
        serve_write(4'd0);
        serve_write(4'd1);
        serve_write(4'd2);
        total++;
        if (bus_if.escribiendo !== 1'b0) begin
            bad++; $display("FAIL il_wr_end: esc=%b want 0", bus_if.escribiendo);
        end
        for (int i = 3; i <= int'(LAST); i++) serve_read(4'(i), 1);
        total++;
        if (bus_if.busy !== 1'b0) begin
            bad++; $display("FAIL il_end: busy=%b want 0", bus_if.busy);
        end
    endtask

    task automatic test_ignored();
        int extra = 0;
        bus_if.wr_req = 1'b1; bus_if.estado = 8'h1c;
        cyc();
        bus_if.wr_req = 1'b0;
        bus_if.bus_done = 1'b1;
        cyc();
        bus_if.bus_done = 1'b0;
        repeat (5) begin cyc(); if (bus_if.busy) extra++; end
        total++;
        if (extra !== 0) begin
            bad++; $display("FAIL bad_code_ignored: busy cycles=%0d want 0", extra);
        end
        bus_if.tick_refresh = 1'b1;
        cyc();
        bus_if.tick_refresh = 1'b0;
        serve_read(4'd0, 0);
        bus_if.tick_refresh = 1'b1;
        cyc();
        bus_if.tick_refresh = 1'b0;
        for (int i = 1; i <= int'(LAST); i++) serve_read(4'(i), 0);
        extra = 0;
        repeat (12) begin cyc(); if (bus_if.bus_req) extra++; end
        total++;
        if (extra !== 0) begin
            bad++; $display("FAIL tick_dropped: req cycles=%0d want 0", extra);
        end
    endtask

    task automatic test_timeout();
        int nreq = 0, nerr = 0, nen = 0;
        bus_if.tick_refresh = 1'b1;
        cyc();
        bus_if.tick_refresh = 1'b0;
        repeat (400) begin
            cyc();
            if (bus_if.bus_req) nreq++;
            if (bus_if.err)     nerr++;
            if (bus_if.en_out)  nen++;
        end
        total++;
        if (nreq !== 256) begin
            bad++; $display("FAIL tmo_req_cycles: got=%0d want 256", nreq);
        end
        total++;
        if (nerr !== 1) begin
            bad++; $display("FAIL tmo_err_pulses: got=%0d want 1", nerr);
        end
        total++;
        if (nen !== 0 || bus_if.busy !== 1'b0) begin
            bad++; $display("FAIL tmo_no_latch: en=%0d busy=%b want 0 0", nen, bus_if.busy);
        end
    endtask

    task automatic test_timer_code();
        bus_if.wr_req = 1'b1; bus_if.estado = 8'h75;
        cyc();
        bus_if.wr_req = 1'b0;
`ifdef CONTROL_RTC_TIMER_EN
        serve_write(4'd6);
        serve_write(4'd7);
        serve_write(4'd8);
        total++;
        if (bus_if.escribiendo !== 1'b0) begin
            bad++; $display("FAIL timer_wr_end: esc=%b want 0", bus_if.escribiendo);
        end
`else
        begin
            int extra = 0;
            repeat (10) begin cyc(); if (bus_if.bus_req) extra++; end
            total++;
            if (extra !== 0) begin
                bad++; $display("FAIL timer_code_ignored: req cycles=%0d want 0", extra);
            end
        end
`endif
    endtask

    task automatic test_reset_mid();
        int n = 0, nerr = 0, nbusy = 0;
        bus_if.tick_refresh = 1'b1;
        cyc();
        bus_if.tick_refresh = 1'b0;
        while (!bus_if.bus_req && n < 10) begin cyc(); n++; end
        cyc();
        #2 reset = 1'b0;
        #1;
        total++;
        if (bus_if.bus_req !== 1'b0 || bus_if.busy !== 1'b0 ||
            bus_if.direccion !== 4'h0 || bus_if.err !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: req=%b busy=%b dir=%0d err=%b want 0 0 0 0",
                     bus_if.bus_req, bus_if.busy, bus_if.direccion, bus_if.err);
        end
        cyc();
        cyc();
        reset = 1'b1;
        repeat (8) begin cyc(); if (bus_if.err) nerr++; if (bus_if.busy) nbusy++; end
        total++;
        if (nerr !== 0 || nbusy !== 0) begin
            bad++; $display("FAIL reset_mid_after: err=%0d busy=%0d want 0 0", nerr, nbusy);
        end
    endtask

    initial begin
        bus_if.tick_refresh = 1'b0;
        bus_if.wr_req       = 1'b0;
        bus_if.estado       = 8'h00;
        bus_if.bus_done     = 1'b0;
        repeat (3) cyc();
        test_reset();
        reset = 1'b1;
        cyc();
        test_sweep();
        test_write_fecha();
        test_interleave();
        test_ignored();
        test_timeout();
        test_timer_code();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_rtc_secuencia.md
CONTROL_RTC_SECUENCIA -- requirements
Module: control_rtc_secuencia

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset (low = reset asserted).
REQ-003 tick_refresh  in  1  one-cycle pulse requesting a display refresh sweep.
REQ-004 wr_req  in  1  one-cycle pulse committing a keyboard edit.
REQ-005 estado  in  8  keyboard scan code sampled with wr_req.
REQ-006 bus_done  in  1  one-cycle pulse from the RTC bus driver ending the current access.
REQ-007 bus_req  out  1  RTC access request, held high until bus_done.
REQ-008 bus_rw  out  1  access type: 0 = read, 1 = write.
REQ-009 direccion  out  4  register address for the digit bank and bus driver.
REQ-010 en_out  out  1  one-cycle strobe telling the digit bank to latch read data.
REQ-011 escribiendo  out  1  high for the whole duration of a write group.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 err  out  1  one-cycle pulse on bus timeout.

Function
REQ-014 States: IDLE, RD_REQ, RD_WAIT, RD_LATCH, WR_REQ, WR_WAIT.
REQ-015 tick_refresh sets a one-deep sweep_pend flag; a tick while sweep_pend is already set is dropped.
REQ-016 wr_req with estado 8'h6c sets wr_pend with group time, addresses 0,1,2.
REQ-017 wr_req with estado 8'h7d sets wr_pend with group date, addresses 3,4,5.
REQ-018 wr_req with estado 8'h75 sets wr_pend with group timer, addresses 6,7,8.
REQ-019 wr_req with any other estado is ignored; wr_req while a write group is active or wr_pend is set is ignored.
REQ-020 IDLE: wr_pend has priority and leads to WR_REQ at the group's first address; otherwise sweep_pend leads to RD_REQ at the resume address (0 on a fresh sweep).
REQ-021 RD_REQ: bus_req=1, bus_rw=0, then RD_WAIT on the next cycle; bus_req stays 1 through RD_WAIT.
REQ-022 RD_WAIT: bus_done leads to RD_LATCH, with bus_req low in the same cycle as the transition.
REQ-023 RD_LATCH: en_out=1 for exactly one cycle with direccion unchanged.
REQ-024 After RD_LATCH at the last address: sweep_pend is cleared and the FSM returns to IDLE.
REQ-025 After RD_LATCH at any other address: the address increments; if wr_pend is set, the FSM goes to IDLE and the sweep later resumes at the incremented address; otherwise it goes to RD_REQ.
REQ-026 WR_REQ/WR_WAIT: bus_req=1, bus_rw=1, escribiendo=1; each bus_done advances to the next group address.
REQ-027 The third bus_done of a write group clears wr_pend and returns the FSM to IDLE, with escribiendo low in the following cycle.
REQ-028 A write always completes all three addresses; a read never interrupts a write group.
REQ-029 Timeout: an 8-bit counter runs in RD_WAIT/WR_WAIT; on reaching 255 cycles without bus_done, err pulses once, the FSM goes to IDLE and the pending flag of the aborted operation is cleared.
REQ-030 A bus_done arriving in any state other than RD_WAIT/WR_WAIT is ignored.
REQ-031 Read latency: tick in IDLE leads to bus_req on cycle +2 (flag set, then RD_REQ).

Reset
REQ-032 With reset low: state=IDLE; sweep_pend, wr_pend and timeout counter cleared; all outputs 0, including direccion=4'h0.
REQ-033 Reset asserted mid-access drops the access immediately with no err pulse.

Configuration
REQ-034 Macro CONTROL_RTC_TIMER_EN defined: the sweep covers addresses 0..8 and scan code 8'h75 is accepted.
REQ-035 Macro CONTROL_RTC_TIMER_EN undefined: the sweep covers addresses 0..5, scan code 8'h75 is ignored, and addresses 6..8 are never driven.

Structure
REQ-036 Package control_rtc_pkg holds: the state enum; address constants ADDR_HO..ADDR_SEG_TI (0..8); scan codes SC_FECHA=8'h7d, SC_HORA=8'h6c, SC_TIMER=8'h75; TIMEOUT_MAX=255.
REQ-037 Sub-module contador_timeout (8-bit, clear/enable/terminal-count) is instantiated once; the rest is a single FSM.

Verification
REQ-038 Reset release, then tick: nine read accesses on direccion 0..8, each followed by one en_out pulse, then busy=0.
REQ-039 wr_req with estado=8'h7d in IDLE: writes to 3,4,5 with bus_rw=1 and escribiendo high throughout; escribiendo low one cycle after the third bus_done.
REQ-040 Tick, then wr_req (8'h6c) during the read of address 2: after latching address 2, writes 0,1,2 follow, then the sweep resumes at address 3.
REQ-041 wr_req with estado=8'h1c, and a second tick during a sweep: both ignored; exactly one sweep is performed.
REQ-042 No bus_done for 255 cycles in RD_WAIT: a single err pulse, busy drops, no en_out.
REQ-043 Build without CONTROL_RTC_TIMER_EN: the sweep ends after address 5, and wr_req with 8'h75 produces no bus_req.
